// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/write-back,
// stalls on the memory ready handshake and traps on illegal opcodes or memory timeout.
module multicycle_control_unit #(
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned WAIT_W  = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic [3:0]         state,
  output logic               instr_done,
  output logic               illegal_op,
  output logic               mem_timeout
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              illegal_q, timeout_q;
  logic              set_illegal, set_timeout;
  logic              in_wait, timed_out;
  logic [2:0]        aop;

  assign in_wait   = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // ready on the TIMEOUT cycle takes priority over the trap
  assign timed_out = !mem_ready && (wait_cnt == WAIT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        wait_cnt <= '0;
      else if (in_wait && !mem_ready)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (set_illegal)
        illegal_q <= 1'b1;
      if (set_timeout)
        timeout_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    aop         = 3'b000;
    pc_source   = 2'b00;
    instr_done  = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timed_out) begin
          mem_read    = 1'b0;
          set_timeout = 1'b1;
          state_d     = S_TRAP;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE: begin
            if (funct != 6'd0) begin
              state_d = S_R_EXEC;
            end else begin
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end
          end
          OP_LW, OP_SW:                       state_d = S_MEM_ADDR;
          OP_BEQ:                             state_d = S_BRANCH;
          OP_J:                               state_d = S_JUMP;
          OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI:  state_d = S_I_EXEC;
          default: begin
            set_illegal = 1'b1;
            state_d     = S_TRAP;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timed_out) begin
          mem_read    = 1'b0;
          set_timeout = 1'b1;
          state_d     = S_TRAP;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (timed_out) begin
          mem_write   = 1'b0;
          set_timeout = 1'b1;
          state_d     = S_TRAP;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        aop       = 3'b010;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          OP_ORI:  aop = 3'b001;
          OP_ANDI: aop = 3'b011;
          OP_SLTI: aop = 3'b111;
          default: aop = 3'b000;
        endcase
        state_d = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        aop        = 3'b110;
        pc_source  = 2'b01;
        pc_write   = zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    alu_op = ALUOP_W'(aop);

    // outputs are quiet for the whole reset cycle, even before the state register clears
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = '0;
      pc_source  = 2'b00;
      instr_done = 1'b0;
    end
  end

  assign state       = reset ? 4'd0 : state_q;
  assign illegal_op  = illegal_q & ~reset;
  assign mem_timeout = timeout_q & ~reset;

endmodule
